balance_pipe_seq: RTL and testbench
===================================

# balance_pipe_seq

Sequencer for the two-stage balance-control pipeline. On each inertial `vld` it snapshots the steering and power context, waits for the PID stage to settle, then loads the stage-2 registers that feed SegwayMath and issues a one-cycle `math_vld` strobe. An optional stale-sensor watchdog forces motor speeds to zero when inertial updates stop.

## Interface
- `PID_LAT`, default 1: clock edges from the `vld` sampling edge until PID stage-1 outputs are stable. Legal range 1..15.
- `STALE_CYC`, default 1_000_000: `vld`-free cycles before the watchdog declares stale data (20 ms at 50 MHz).
- `fast_sim`, default 1: when 1, the effective stale threshold is 1024 cycles.
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `vld` in 1: inertial pitch sample ready; single-cycle pulse.
- `pwr_up` in 1: live power-up request.
- `en_steer` in 1: steering enable from the rider/load-cell logic.
- `steer_pot` in 12: steering pot reading from A2D_intf.
- `PID_cntrl_stage1` in 12, signed: PID output.
- `ss_tmr_stage1` in 8: PID soft-start timer.
- `PID_cntrl_pipe2` out 12, signed: stage-2 PID value.
- `ss_tmr_pipe2` out 8: stage-2 soft-start value.
- `steer_pot_pipe2` out 12: stage-2 steering value, aligned to the same `vld`.
- `en_steer_pipe2` out 1: stage-2 steering enable.
- `pwr_up_pipe2` out 1: stage-2 power-up.
- `math_vld` out 1: one-cycle strobe; stage-2 registers were updated at the preceding edge.
- `ovr` out 1: one-cycle pulse; a pending sample was discarded.
- `stale` out 1: watchdog tripped.

## Operation
- **States:**
  - IDLE: waiting for `vld`.
  - WAIT: counting to `PID_LAT`; the counter is 4 bits.
- **IDLE, `vld`=1:**
  - Latch `steer_pot`, `en_steer` and `pwr_up` into the side registers.
  - Set cnt=`PID_LAT`-1 and go to WAIT.
- **WAIT, cnt>0:** decrement cnt.
- **WAIT, cnt==0 (capture edge):**
  - Load `PID_cntrl_pipe2`/`ss_tmr_pipe2` from the stage-1 inputs.
  - Load the steer/enable outputs from the side registers.
  - Load `pwr_up_pipe2` with side `pwr_up` AND live `pwr_up`.
  - Set `math_vld` for the next cycle.
  - Go to IDLE.
- **`vld` in WAIT with cnt>0 (overrun):**
  - Discard the pending sample; `ovr` pulses for one cycle.
  - Relatch the side registers and reload cnt=`PID_LAT`-1.
  - No capture occurs for the discarded sample.
- **`vld` on the capture edge:** the capture completes with the old sample, and the new sample is accepted into WAIT (cnt reloaded). No `ovr`.
- **Live `pwr_up` low in any state:** `pwr_up_pipe2` clears at the next edge. Other stage-2 registers hold. A pending capture still completes, with `pwr_up_pipe2`=0.
- Stage-2 registers change only on a capture edge, a `pwr_up` drop, or watchdog action. They hold otherwise.
- SegwayMath is combinational, so `lft_spd`/`rght_spd` are valid in the `math_vld` cycle.

## Timing
- **Reset values:** all outputs 0, state IDLE, cnt 0, side registers 0, watchdog counter 0.
- **Latency:** `vld` sampled at edge E0 gives the stage-2 load at edge E`PID_LAT`. `math_vld` is high in the cycle after E`PID_LAT`.
- **Throughput:** one sample per `PID_LAT` cycles. Back-to-back `vld` at that spacing never flags `ovr`.
- **Reset mid-WAIT:** the sample is lost, there is no `math_vld`, and the block returns to IDLE.

## Configuration
- **`BAL_WDOG_EN` defined:** a 20-bit counter clears on every `vld` and saturates.
  - When the counter reaches the threshold minus 1, `stale` is set at the next edge.
  - On that same edge, `PID_cntrl_pipe2`, `ss_tmr_pipe2` and `pwr_up_pipe2` are forced to 0; SegwayMath then outputs zero speed.
  - `stale` clears on the next capture edge.
  - The threshold is `STALE_CYC`, or 1024 when `fast_sim`=1.
- **`BAL_WDOG_EN` undefined:** there is no counter and `stale` is tied to 0.

## Test plan
- **Reset:** `rst_n` low mid-WAIT -> all outputs 0 immediately. No `math_vld` after release.
- **Nominal capture:** `PID_LAT`=1; `vld` with `PID_cntrl_stage1`=12'sh1F4, `steer_pot`=12'h800, `pwr_up`=1 -> one edge later, `PID_cntrl_pipe2`=12'sh1F4, `steer_pot_pipe2`=12'h800, `pwr_up_pipe2`=1, then `math_vld` for 1 cycle.
- **Overrun:** `PID_LAT`=4; `vld` at cycle 0 and cycle 2 -> `ovr` pulses once. A single `math_vld` follows, 4 edges after the second `vld`, carrying the second sample's `steer_pot`.
- **Capture-edge `vld`:** `PID_LAT`=4; `vld` at cycles 0 and 4 -> two captures, at edges 4 and 8. `ovr` stays 0.
- **Power drop:** `pwr_up` falls during WAIT -> `pwr_up_pipe2`=0 at the next edge. The capture still loads `PID_cntrl_pipe2` and `math_vld` still pulses.
- **Watchdog (`BAL_WDOG_EN`, `fast_sim`=1):** no `vld` for 1024 cycles -> `stale`=1, with `PID_cntrl_pipe2`=0 and `pwr_up_pipe2`=0. The next `vld` plus capture clears `stale`.

Source files
------------

// File: rtl/balance_pipe_seq.sv
// Balance-control pipeline sequencer: snapshots steering/power context on vld,
// waits PID_LAT edges, then loads the stage-2 registers and strobes math_vld.
// Optional stale-sensor watchdog is enabled with `define BAL_WDOG_EN.
module balance_pipe_seq #(
    parameter int unsigned PID_LAT   = 1,
    parameter int unsigned STALE_CYC = 1_000_000,
    parameter bit          fast_sim  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic        pwr_up,
    input  logic        en_steer,
    input  logic [11:0] steer_pot,
    input  logic signed [11:0] PID_cntrl_stage1,
    input  logic [7:0]  ss_tmr_stage1,
    output logic signed [11:0] PID_cntrl_pipe2,
    output logic [7:0]  ss_tmr_pipe2,
    output logic [11:0] steer_pot_pipe2,
    output logic        en_steer_pipe2,
    output logic        pwr_up_pipe2,
    output logic        math_vld,
    output logic        ovr,
    output logic        stale
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WDOG_W   = 20;
    localparam int unsigned THRESH   = fast_sim ? 32'd1024 : STALE_CYC;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PID_LAT - 1);
    localparam logic [WDOG_W-1:0] TRIP_AT  = WDOG_W'(THRESH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               capture_c;
    logic               relatch_c;
    logic               ovr_d;
    logic               trip_c;

    logic [11:0]        side_steer_q;
    logic               side_en_q;
    logic               side_pwr_q;

    logic signed [11:0] pid_q;
    logic [7:0]         ss_q;
    logic [11:0]        steer_q;
    logic               en_q;
    logic               pwr_q;
    logic               math_vld_q;
    logic               ovr_q;

    // State and latency counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a vld on the capture edge chains straight into a new WAIT
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        relatch_c = 1'b0;
        ovr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (vld) begin
                    relatch_c = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    if (vld) begin
                        ovr_d     = 1'b1;
                        relatch_c = 1'b1;
                        cnt_d     = CNT_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    capture_c = 1'b1;
                    if (vld) begin
                        relatch_c = 1'b1;
                        cnt_d     = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Side registers hold the steering/power context of the pending sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            side_steer_q <= '0;
            side_en_q    <= 1'b0;
            side_pwr_q   <= 1'b0;
        end else if (relatch_c) begin
            side_steer_q <= steer_pot;
            side_en_q    <= en_steer;
            side_pwr_q   <= pwr_up;
        end
    end

    // Stage-2 registers; watchdog zeroing takes precedence over a capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_q      <= '0;
            ss_q       <= '0;
            steer_q    <= '0;
            en_q       <= 1'b0;
            pwr_q      <= 1'b0;
            math_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            math_vld_q <= capture_c;
            ovr_q      <= ovr_d;
            if (capture_c) begin
                pid_q   <= PID_cntrl_stage1;
                ss_q    <= ss_tmr_stage1;
                steer_q <= side_steer_q;
                en_q    <= side_en_q;
                pwr_q   <= side_pwr_q & pwr_up;
            end else if (!pwr_up) begin
                pwr_q <= 1'b0;
            end
            if (trip_c) begin
                pid_q <= '0;
                ss_q  <= '0;
                pwr_q <= 1'b0;
            end
        end
    end

`ifdef BAL_WDOG_EN
    logic [WDOG_W-1:0] wdog_q;
    logic              stale_q;

    assign trip_c = (wdog_q == TRIP_AT);

    // Saturating vld-free cycle counter; stale holds until the next capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q  <= '0;
            stale_q <= 1'b0;
        end else begin
            if (vld) begin
                wdog_q <= '0;
            end else if (wdog_q != '1) begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end
            if (trip_c) begin
                stale_q <= 1'b1;
            end else if (capture_c) begin
                stale_q <= 1'b0;
            end
        end
    end

    assign stale = stale_q;
`else
    logic unused_wdog_cfg;

    assign trip_c          = 1'b0;
    assign stale           = 1'b0;
    assign unused_wdog_cfg = ^TRIP_AT;
`endif

    assign PID_cntrl_pipe2 = pid_q;
    assign ss_tmr_pipe2    = ss_q;
    assign steer_pot_pipe2 = steer_q;
    assign en_steer_pipe2  = en_q;
    assign pwr_up_pipe2    = pwr_q;
    assign math_vld        = math_vld_q;
    assign ovr             = ovr_q;

endmodule

// File: tb/tb_balance_pipe_seq.sv
// Directed bench for balance_pipe_seq: one instance with PID_LAT=1, one with PID_LAT=4.
module tb_balance_pipe_seq;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic        pwr_up;
    logic        en_steer;
    logic [11:0] steer_pot;
    logic [11:0] pid_in;
    logic [7:0]  ss_in;

    logic [11:0] a_pid, b_pid;
    logic [7:0]  a_ss, b_ss;
    logic [11:0] a_steer, b_steer;
    logic        a_en, b_en, a_pwr, b_pwr, a_mv, b_mv, a_ovr, b_ovr, a_stale, b_stale;

    int n_vec = 0;
    int n_err = 0;

    balance_pipe_seq #(.PID_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .vld(vld), .pwr_up(pwr_up), .en_steer(en_steer),
        .steer_pot(steer_pot), .PID_cntrl_stage1(pid_in), .ss_tmr_stage1(ss_in),
        .PID_cntrl_pipe2(a_pid), .ss_tmr_pipe2(a_ss), .steer_pot_pipe2(a_steer),
        .en_steer_pipe2(a_en), .pwr_up_pipe2(a_pwr), .math_vld(a_mv), .ovr(a_ovr),
        .stale(a_stale)
    );

    balance_pipe_seq #(.PID_LAT(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n), .vld(vld), .pwr_up(pwr_up), .en_steer(en_steer),
        .steer_pot(steer_pot), .PID_cntrl_stage1(pid_in), .ss_tmr_stage1(ss_in),
        .PID_cntrl_pipe2(b_pid), .ss_tmr_pipe2(b_ss), .steer_pot_pipe2(b_steer),
        .en_steer_pipe2(b_en), .pwr_up_pipe2(b_pwr), .math_vld(b_mv), .ovr(b_ovr),
        .stale(b_stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        vld       = 1'b0;
        pwr_up    = 1'b0;
        en_steer  = 1'b0;
        steer_pot = '0;
        pid_in    = '0;
        ss_in     = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_pid",   32'(b_pid),   32'h0);
        chk("rst_steer", 32'(b_steer), 32'h0);
        chk("rst_pwr",   32'(b_pwr),   32'h0);
        chk("rst_mv",    32'(b_mv),    32'h0);
        chk("rst_ovr",   32'(b_ovr),   32'h0);
        chk("rst_stale", 32'(b_stale), 32'h0);

        // Nominal capture, PID_LAT=1
        pwr_up = 1'b1; en_steer = 1'b1; steer_pot = 12'h800; pid_in = 12'h1F4; ss_in = 8'h40;
        vld = 1'b1;
        step();
        vld = 1'b0;
        chk("nom_mv_e0",  32'(a_mv),  32'h0);
        chk("nom_pid_e0", 32'(a_pid), 32'h0);
        step();
        chk("nom_pid",   32'(a_pid),   32'h1F4);
        chk("nom_steer", 32'(a_steer), 32'h800);
        chk("nom_pwr",   32'(a_pwr),   32'h1);
        chk("nom_en",    32'(a_en),    32'h1);
        chk("nom_ss",    32'(a_ss),    32'h40);
        chk("nom_mv",    32'(a_mv),    32'h1);
        step();
        chk("nom_mv_off", 32'(a_mv), 32'h0);
        for (int i = 0; i < 3; i++) step();

        // Overrun, PID_LAT=4: vld at cycles 0 and 2
        steer_pot = 12'h111; pid_in = 12'h0A0; vld = 1'b1;
        step();
        vld = 1'b0;
        chk("ovr_e0", 32'(b_ovr), 32'h0);
        step();
        steer_pot = 12'h222; pid_in = 12'h0B0; vld = 1'b1;
        step();
        vld = 1'b0;
        chk("ovr_pulse", 32'(b_ovr), 32'h1);
        chk("ovr_mv_e2", 32'(b_mv),  32'h0);
        steer_pot = 12'h333; pid_in = 12'h0C0;
        for (int i = 3; i <= 5; i++) begin
            step();
            chk($sformatf("ovr_ovr_e%0d", i), 32'(b_ovr), 32'h0);
            chk($sformatf("ovr_mv_e%0d", i),  32'(b_mv),  32'h0);
        end
        step();
        chk("ovr_cap_mv",    32'(b_mv),    32'h1);
        chk("ovr_cap_steer", 32'(b_steer), 32'h222);
        chk("ovr_cap_pid",   32'(b_pid),   32'h0C0);
        step();
        chk("ovr_mv_off", 32'(b_mv), 32'h0);

        // vld on the capture edge, PID_LAT=4: vld at cycles 0 and 4
        steer_pot = 12'h444; vld = 1'b1;
        step();
        vld = 1'b0; steer_pot = 12'h555;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("ce_ovr_e%0d", i), 32'(b_ovr), 32'h0);
        end
        vld = 1'b1; pid_in = 12'h0D0;
        step();
        vld = 1'b0;
        chk("ce_cap1_mv",    32'(b_mv),    32'h1);
        chk("ce_cap1_steer", 32'(b_steer), 32'h444);
        chk("ce_cap1_pid",   32'(b_pid),   32'h0D0);
        chk("ce_ovr_e4",     32'(b_ovr),   32'h0);
        pid_in = 12'h0E0; steer_pot = 12'h666;
        for (int i = 5; i <= 7; i++) begin
            step();
            chk($sformatf("ce_ovr_e%0d", i), 32'(b_ovr), 32'h0);
            chk($sformatf("ce_mv_e%0d", i),  32'(b_mv),  32'h0);
        end
        step();
        chk("ce_cap2_mv",    32'(b_mv),    32'h1);
        chk("ce_cap2_steer", 32'(b_steer), 32'h555);
        chk("ce_cap2_pid",   32'(b_pid),   32'h0E0);
        chk("ce_ovr_e8",     32'(b_ovr),   32'h0);
        step();

        // Power drop during WAIT
        chk("pd_pwr_before", 32'(b_pwr), 32'h1);
        pid_in = 12'h123; steer_pot = 12'h777; vld = 1'b1;
        step();
        vld = 1'b0;
        step();
        pwr_up = 1'b0;
        step();
        chk("pd_pwr_drop", 32'(b_pwr), 32'h0);
        chk("pd_pid_hold", 32'(b_pid), 32'h0E0);
        chk("pd_mv_e2",    32'(b_mv),  32'h0);
        step();
        step();
        chk("pd_cap_pid",   32'(b_pid),   32'h123);
        chk("pd_cap_steer", 32'(b_steer), 32'h777);
        chk("pd_cap_pwr",   32'(b_pwr),   32'h0);
        chk("pd_cap_mv",    32'(b_mv),    32'h1);
        pwr_up = 1'b1;
        step();

        // Reset mid-WAIT
        steer_pot = 12'h999; vld = 1'b1;
        step();
        vld = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rw_pid",   32'(b_pid),   32'h0);
        chk("rw_steer", 32'(b_steer), 32'h0);
        chk("rw_en",    32'(b_en),    32'h0);
        chk("rw_ss",    32'(b_ss),    32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rw_mv_%0d", i), 32'(b_mv), 32'h0);
        end

`ifdef BAL_WDOG_EN
        // Watchdog trips after 1024 vld-free cycles, zeroing PID and power
        pid_in = 12'h321; ss_in = 8'h55; vld = 1'b1;
        step();
        vld = 1'b0;
        for (int i = 1; i <= 1023; i++) step();
        chk("wd_stale_pre", 32'(b_stale), 32'h0);
        chk("wd_pid_pre",   32'(b_pid),   32'h321);
        chk("wd_pwr_pre",   32'(b_pwr),   32'h1);
        step();
        chk("wd_stale", 32'(b_stale), 32'h1);
        chk("wd_pid",   32'(b_pid),   32'h0);
        chk("wd_ss",    32'(b_ss),    32'h0);
        chk("wd_pwr",   32'(b_pwr),   32'h0);
        vld = 1'b1;
        step();
        vld = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        chk("wd_stale_hold", 32'(b_stale), 32'h1);
        step();
        chk("wd_stale_clr", 32'(b_stale), 32'h0);
        chk("wd_cap_pid",   32'(b_pid),   32'h321);
        chk("wd_cap_mv",    32'(b_mv),    32'h1);
`else
        for (int i = 0; i < 20; i++) step();
        chk("nowd_stale", 32'(b_stale), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
